voice: RTL and testbench
========================

VOICE -- requirements
Module: voice

Interface
REQ-001 Parameter PHASE_W, default 24: phase accumulator width in bits.
REQ-002 Parameter DECAY_DIV, default 256: sample ticks per envelope decrement step.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 grst  input  1  reset, synchronous and active-high.
REQ-005 tick  input  1  sample-rate strobe, one clk cycle wide.
REQ-006 rst  input  1  per-voice note reset from the score stage, level-sensitive.
REQ-007 key  input  7  note number from the score stage; 0 means rest, 1..127 means semitone index.
REQ-008 sample  output  12  signed two's-complement voice sample.
REQ-009 sample_valid  output  1  one-cycle pulse marking a new sample.
REQ-010 busy  output  1  high while a note-start computation is in progress (states DIV or LOAD).

Function
REQ-011 The FSM SHALL have four states: IDLE, DIV, LOAD and RUN.
REQ-012 In any state, rst=1 or key=0 SHALL force IDLE on the next edge; IDLE has highest priority after grst.
REQ-013 In IDLE, if rst=0 and key!=0, the block SHALL latch key into kreg, set rem=key and oct=0, and enter DIV.
REQ-014 In RUN, if rst=0 and key!=kreg and key!=0, the block SHALL re-latch and enter DIV, with no tick processed that cycle.
REQ-015 In DIV, each cycle: if rem>=12 then rem-=12 and oct+=1 (4-bit oct, 0..10), else enter LOAD.
REQ-016 In LOAD, the block SHALL set inc = BASE[rem] >> (10-oct) (PHASE_W bits, truncating), phase=0, env=255 and decay counter=0, then enter RUN.
REQ-017 BASE[s] for s=0..11 SHALL equal round(2926230 * 2^(s/12)), i.e. octave-10 increments for 48 kHz tick at PHASE_W=24, held in a constant table.
REQ-018 Note-start latency SHALL be floor(key/12)+2 cycles from the latch edge to RUN (maximum 12 cycles).
REQ-019 On tick in RUN, phase SHALL become phase+inc modulo 2^PHASE_W (natural wrap, no saturation).
REQ-020 On tick in RUN, the decay counter SHALL increment; when it reaches DECAY_DIV-1 it SHALL clear and env SHALL decrement by 1, saturating at 0.
REQ-021 sample_valid SHALL pulse exactly one cycle after every tick seen in RUN.
REQ-022 On a sample_valid pulse, sample SHALL carry the updated phase and env: +(env*8) if phase[PHASE_W-1]=0, else -(env*8); range -2040..+2040.
REQ-023 In IDLE, DIV and LOAD, sample SHALL be 0 and sample_valid SHALL be 0.
REQ-024 A tick arriving in IDLE, DIV or LOAD SHALL be dropped, not queued.
REQ-025 When key and tick change in the same cycle in RUN, the key change SHALL win and the tick SHALL be dropped.
REQ-026 sample SHALL hold its value between sample_valid pulses.
REQ-027 When env reaches 0, the state SHALL remain RUN (phase keeps advancing) and sample SHALL be 0.

Reset
REQ-028 grst=1 SHALL on the next edge set state=IDLE, phase=0, inc=0, env=0, kreg=0, rem=0, oct=0, decay counter=0, sample=0, sample_valid=0, busy=0.
REQ-029 grst SHALL override rst, key and tick, including mid-DIV and mid-RUN, with no partial state retained.

Verification
REQ-030 grst pulse, then rst=0, key=69 -> busy for 7 cycles (DIV 6, LOAD 1), RUN with inc=BASE[9]>>5=153791, env=255.
REQ-031 In RUN at key=69, 5 ticks -> 5 sample_valid pulses each one cycle after tick; first sample=+2040; phase=768955 after 5 ticks.
REQ-032 key=127 -> DIV lasts 11 cycles with oct=10 and rem=7; inc=BASE[7]; tick during DIV yields no sample_valid.
REQ-033 DECAY_DIV=4, 1024 ticks in RUN -> env reaches 0 at tick 1020 and stays 0; sample=0 thereafter; state remains RUN.
REQ-034 rst=1 mid-RUN -> IDLE next edge, sample=0; rst=0 with same key -> full note restart, env=255, phase=0.
REQ-035 key changes 60->61 together with tick in RUN -> tick dropped, DIV restarts, new inc=BASE[1]>>5.

Source files
------------

// File: rtl/voice.sv
// Single synthesizer voice: key -> octave/semitone decode, phase accumulator
// square-wave oscillator with a linear decay envelope.
module voice #(
  parameter int PHASE_W   = 24,
  parameter int DECAY_DIV = 256
) (
  input  logic               clk,
  input  logic               grst,
  input  logic               tick,
  input  logic               rst,
  input  logic [6:0]         key,
  output logic signed [11:0] sample,
  output logic               sample_valid,
  output logic               busy
);

  localparam int DW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DECAY_DIV - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    LOAD = 2'd2,
    RUN  = 2'd3
  } state_e;

  // Octave-10 phase increments for a 48 kHz tick at 24-bit phase.
  function automatic logic [31:0] base_f(input logic [3:0] s);
    case (s)
      4'd0:    base_f = 32'd2926230;
      4'd1:    base_f = 32'd3100233;
      4'd2:    base_f = 32'd3284582;
      4'd3:    base_f = 32'd3479894;
      4'd4:    base_f = 32'd3686819;
      4'd5:    base_f = 32'd3906048;
      4'd6:    base_f = 32'd4138314;
      4'd7:    base_f = 32'd4384391;
      4'd8:    base_f = 32'd4645101;
      4'd9:    base_f = 32'd4921313;
      4'd10:   base_f = 32'd5213949;
      4'd11:   base_f = 32'd5523987;
      default: base_f = 32'd0;
    endcase
  endfunction

  state_e               state_q, state_d;
  logic [6:0]           kreg_q, kreg_d;
  logic [6:0]           rem_q, rem_d;
  logic [3:0]           oct_q, oct_d;
  logic [PHASE_W-1:0]   inc_q, inc_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [7:0]           env_q, env_d;
  logic [DW-1:0]        dcnt_q, dcnt_d;
  logic [11:0]          sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic                 busy_q;

  logic [PHASE_W-1:0]   phase_adv;
  logic [7:0]           env_adv;
  logic [DW-1:0]        dcnt_adv;
  logic [11:0]          mag;
  logic [31:0]          shifted;

  // State and datapath registers with synchronous global reset.
  always_ff @(posedge clk) begin
    if (grst) begin
      state_q  <= IDLE;
      kreg_q   <= 7'd0;
      rem_q    <= 7'd0;
      oct_q    <= 4'd0;
      inc_q    <= '0;
      phase_q  <= '0;
      env_q    <= 8'd0;
      dcnt_q   <= '0;
      sample_q <= 12'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      kreg_q   <= kreg_d;
      rem_q    <= rem_d;
      oct_q    <= oct_d;
      inc_q    <= inc_d;
      phase_q  <= phase_d;
      env_q    <= env_d;
      dcnt_q   <= dcnt_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= (state_d == DIV) || (state_d == LOAD);
    end
  end

  // Next-state and datapath update; one tick advances phase and decay together.
  always_comb begin
    state_d  = state_q;
    kreg_d   = kreg_q;
    rem_d    = rem_q;
    oct_d    = oct_q;
    inc_d    = inc_q;
    phase_d  = phase_q;
    env_d    = env_q;
    dcnt_d   = dcnt_q;
    sample_d = sample_q;
    valid_d  = 1'b0;

    phase_adv = phase_q + inc_q;
    if (dcnt_q == D_LAST) begin
      dcnt_adv = '0;
      env_adv  = (env_q != 8'd0) ? (env_q - 8'd1) : 8'd0;
    end else begin
      dcnt_adv = dcnt_q + D_ONE;
      env_adv  = env_q;
    end
    mag     = {1'b0, env_adv, 3'b000};
    shifted = base_f(rem_q[3:0]) >> (4'd10 - oct_q);

    if (rst || (key == 7'd0)) begin
      state_d  = IDLE;
      sample_d = 12'd0;
    end else begin
      case (state_q)
        IDLE: begin
          kreg_d  = key;
          rem_d   = key;
          oct_d   = 4'd0;
          state_d = DIV;
        end
        DIV: begin
          if (rem_q >= 7'd12) begin
            rem_d = rem_q - 7'd12;
            oct_d = oct_q + 4'd1;
          end else begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          inc_d   = PHASE_W'(shifted);
          phase_d = '0;
          env_d   = 8'd255;
          dcnt_d  = '0;
          state_d = RUN;
        end
        RUN: begin
          // A new key pre-empts any tick arriving in the same cycle.
          if (key != kreg_q) begin
            kreg_d   = key;
            rem_d    = key;
            oct_d    = 4'd0;
            sample_d = 12'd0;
            state_d  = DIV;
          end else if (tick) begin
            phase_d  = phase_adv;
            env_d    = env_adv;
            dcnt_d   = dcnt_adv;
            sample_d = phase_adv[PHASE_W-1] ? (12'd0 - mag) : mag;
            valid_d  = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end
        default: begin
          state_d  = IDLE;
          sample_d = 12'd0;
        end
      endcase
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_voice.sv
// Randomized scoreboard bench for voice: a closed-form note model predicts
// busy, sample_valid and every sample value.
module tb_voice;

  localparam int PW = 24;
  localparam int DD = 4;

  logic               clk = 1'b0;
  logic               grst = 1'b1;
  logic               tick = 1'b0;
  logic               rst = 1'b0;
  logic [6:0]         key = 7'd0;
  logic signed [11:0] sample;
  logic               sample_valid;
  logic               busy;

  voice #(.PHASE_W(PW), .DECAY_DIV(DD)) dut (
    .clk(clk), .grst(grst), .tick(tick), .rst(rst), .key(key),
    .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  // Note model: a note latched at edge L with key k is running from edge
  // L + k/12 + 2 onward; after n accepted ticks phase = n*inc, env = 255 - n/DD.
  bit     m_active = 1'b0;
  int     m_key = 0;
  int     m_run_edge = 0;
  int     m_ticks = 0;
  int     m_last = 0;
  longint m_inc = 0;
  int     edge_n = 0;
  int     cur_key = 0;

  function automatic longint base_of(int s);
    return longint'($rtoi(2926230.0 * $pow(2.0, real'(s) / 12.0) + 0.5));
  endfunction

  task automatic check(string name, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic start_note(int k);
    m_active   = 1'b1;
    m_key      = k;
    m_run_edge = edge_n + k / 12 + 2;
    m_ticks    = 0;
    m_last     = 0;
    m_inc      = (base_of(k % 12) >> (10 - k / 12)) & ((64'd1 << PW) - 1);
  endtask

  task automatic step(bit g, bit r, int k, bit t);
    bit     in_run;
    bit     exp_valid;
    bit     exp_busy;
    int     exp_sample;
    int     env;
    longint ph;
    grst = g; rst = r; key = k[6:0]; tick = t;
    @(posedge clk);
    edge_n++;
    in_run    = m_active && (edge_n - 1 >= m_run_edge);
    exp_valid = 1'b0;
    if (g || r || k == 0) begin
      m_active = 1'b0;
      m_last   = 0;
    end else if (!m_active || (in_run && k != m_key)) begin
      start_note(k);
    end else if (in_run && t) begin
      m_ticks++;
      ph  = (longint'(m_ticks) * m_inc) & ((64'd1 << PW) - 1);
      env = 255 - m_ticks / DD;
      if (env < 0) env = 0;
      m_last = ((ph >> (PW - 1)) & 1) != 0 ? -(env * 8) : env * 8;
      exp_q.push_back(m_last);
      exp_valid = 1'b1;
    end
    exp_busy   = m_active && (edge_n < m_run_edge);
    exp_sample = (m_active && edge_n >= m_run_edge) ? m_last : 0;
    #1;
    check("busy", busy, exp_busy);
    check("sample_valid", sample_valid, exp_valid);
    check("sample_hold", sample, exp_sample);
  endtask

  // Scoreboard monitor: pops one expected sample per observed pulse.
  always @(posedge clk) begin
    #2;
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid at edge %0d: got sample %0d expected no pulse", edge_n, sample);
      end else begin
        int x;
        x = exp_q.pop_front();
        check("scoreboard_sample", sample, x);
      end
    end
  end

  initial begin
    repeat (3) step(1'b1, 1'b0, 0, 1'b0);

    // Note 69: DIV 6 + LOAD 1, then five spaced ticks and random ticks.
    repeat (9) step(1'b0, 1'b0, 69, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 69, 1'b1);
      step(1'b0, 1'b0, 69, 1'b0);
    end
    repeat (40) step(1'b0, 1'b0, 69, 1'($urandom_range(0, 1)));

    // Per-voice reset mid-run, then full restart of the same key.
    step(1'b0, 1'b1, 69, 1'b1);
    step(1'b0, 1'b1, 69, 1'b0);
    repeat (10) step(1'b0, 1'b0, 69, 1'b1);
    repeat (20) step(1'b0, 1'b0, 69, 1'($urandom_range(0, 1)));

    // Highest key with ticks held during the long DIV phase.
    repeat (16) step(1'b0, 1'b0, 127, 1'b1);
    repeat (30) step(1'b0, 1'b0, 127, 1'($urandom_range(0, 1)));

    // Key change 60 -> 61 coinciding with a tick.
    repeat (10) step(1'b0, 1'b0, 60, 1'b0);
    repeat (20) step(1'b0, 1'b0, 60, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 61, 1'b1);
    repeat (8) step(1'b0, 1'b0, 61, 1'b0);
    repeat (20) step(1'b0, 1'b0, 61, 1'($urandom_range(0, 1)));

    // Global reset mid-DIV and mid-RUN.
    step(1'b0, 1'b0, 100, 1'b0);
    step(1'b0, 1'b0, 100, 1'b0);
    step(1'b1, 1'b0, 100, 1'b1);
    repeat (15) step(1'b0, 1'b0, 100, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0, 100, 1'b1);
    step(1'b0, 1'b0, 0, 1'b0);

    // Full envelope decay to zero and beyond.
    repeat (8) step(1'b0, 1'b0, 69, 1'b0);
    for (int i = 0; i < 1030; i++) begin
      step(1'b0, 1'b0, 69, 1'b1);
      step(1'b0, 1'b0, 69, 1'b0);
    end

    // Random keys, rests, note resets and ticks.
    cur_key = 69;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0)
        cur_key = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      step(1'b0, 1'($urandom_range(0, 40) == 0), cur_key, 1'($urandom_range(0, 1)));
    end
    repeat (4) step(1'b0, 1'b0, cur_key, 1'b0);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_samples: got %0d outstanding expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
